// File: rtl/waveform_channel_pkg.sv
// Shared definitions for the waveform playback channel: time width, reserved
// channel ID, state encoding and conditioned-input indices.
package waveform_channel_pkg;

  localparam int TW_DEF = 32;
  localparam logic [7:0] CH_RESERVED = 8'd255;

  localparam int NUM_SYNC      = 7;
  localparam int SY_WAVEFORM   = 0;
  localparam int SY_INIT_VAL   = 1;
  localparam int SY_VAL_FORCED = 2;
  localparam int SY_ARM        = 3;
  localparam int SY_TO_INIT    = 4;
  localparam int SY_TIME_RDY   = 5;
  localparam int SY_VAL_RDY    = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FORCED = 3'd4
  } state_e;

  function automatic logic ch_hit(input logic [7:0] ch, input logic [7:0] id);
    return (ch == id) && (ch != CH_RESERVED);
  endfunction

endpackage

// File: rtl/waveform_channel_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; level_o is the
// synchronized level, pulse_o is high for one cycle per rising edge.
module waveform_channel_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic pulse_o
);

  logic meta_q, sync_q, dly_q;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign pulse_o = sync_q & ~dly_q;

endmodule

// File: rtl/waveform_channel.sv
// Per-channel playback stage: stores toggle times and values addressed to CH_ID
// and toggles oCH_OUT whenever the shared timebase reaches the next stored time.
module waveform_channel
  import waveform_channel_pkg::*;
#(
  parameter logic [7:0] CH_ID = 8'd0,
  parameter int         DEPTH = 256,
  parameter int         TW    = TW_DEF,
  parameter int         AW    = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iMODE_SET_CH_WAVEFORM,
  input  logic          iMODE_SET_CH_INIT_VAL,
  input  logic          iMODE_SET_CH_VAL_FORCED,
  input  logic          iMODE_CMD_ARM,
  input  logic          iMODE_CMD_TO_INIT,
  input  logic          iFLAG_TIME_READY,
  input  logic          iFLAG_CH_VAL_READY,
  input  logic [7:0]    iDATA_CHANNEL,
  input  logic [TW-1:0] iDATA_TIME,
  input  logic          iDATA_CH_VAL,
  input  logic [TW-1:0] iTIME,
  input  logic          iTIME_ZERO,
  output logic          oCH_OUT,
  output logic          oARMED,
  output logic          oRUNNING,
  output logic [AW:0]   oCOUNT,
  output logic          oOVERFLOW
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};

  logic [NUM_SYNC-1:0] raw_s, lvl_s, evt_s;
  logic                unused_lvl_s;

  state_e        state_q, state_d;
  logic          ch_out_q, ch_out_d;
  logic          init_q, init_d;
  logic          ovf_q, ovf_d;
  logic          armed_q, running_q;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] cmp_time_q;
  logic [TW-1:0] mem_q [DEPTH];

  logic ch_match_s, wr_en_s, forced_ev_s;

  assign raw_s = {iFLAG_CH_VAL_READY, iFLAG_TIME_READY, iMODE_CMD_TO_INIT,
                  iMODE_CMD_ARM, iMODE_SET_CH_VAL_FORCED, iMODE_SET_CH_INIT_VAL,
                  iMODE_SET_CH_WAVEFORM};

  for (genvar g = 0; g < NUM_SYNC; g++) begin : g_sync
    waveform_channel_sync_edge u_sync (
      .clk_i   (iCLK),
      .rst_i   (iRST),
      .d_i     (raw_s[g]),
      .level_o (lvl_s[g]),
      .pulse_o (evt_s[g])
    );
  end

  // Commands and flags are only consumed as edges; their levels are not needed.
  assign unused_lvl_s = ^lvl_s[SY_VAL_RDY:SY_ARM];

  assign ch_match_s  = ch_hit(iDATA_CHANNEL, CH_ID);
  assign forced_ev_s = evt_s[SY_VAL_RDY] & lvl_s[SY_VAL_FORCED] & ch_match_s;

  // Next-state logic; priority: waveform entry > TO_INIT > forced > ARM > zero > match.
  always_comb begin
    state_d  = state_q;
    ch_out_d = ch_out_q;
    init_d   = init_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q;
    wr_en_s  = 1'b0;

    if (evt_s[SY_VAL_RDY] && lvl_s[SY_INIT_VAL] && ch_match_s) begin
      init_d = iDATA_CH_VAL;
    end else begin
      init_d = init_q;
    end

    // A zero time is the decoder's empty-channel marker and is never stored.
    if (evt_s[SY_TIME_RDY] && lvl_s[SY_WAVEFORM] && ch_match_s && (iDATA_TIME != {TW{1'b0}})) begin
      if (count_q < DEPTH_C) begin
        wr_en_s = 1'b1;
        count_d = count_q + ONE_C;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end

    if (evt_s[SY_WAVEFORM]) begin
      count_d  = ZERO_C;
      ovf_d    = 1'b0;
      wr_en_s  = 1'b0;
      state_d  = ST_IDLE;
      rd_ptr_d = ZERO_C;
      ch_out_d = init_d;
    end else if (evt_s[SY_TO_INIT]) begin
      state_d  = ST_IDLE;
      ch_out_d = init_d;
    end else if (forced_ev_s) begin
      state_d  = ST_FORCED;
      ch_out_d = iDATA_CH_VAL;
    end else if (evt_s[SY_ARM] && ((state_q == ST_IDLE) || (state_q == ST_FORCED))) begin
      state_d  = ST_ARMED;
      rd_ptr_d = ZERO_C;
      ch_out_d = init_d;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ch_out_d = init_d;
        end
        ST_ARMED: begin
          ch_out_d = init_d;
          if (iTIME_ZERO) begin
            state_d  = (count_q == ZERO_C) ? ST_DONE : ST_RUN;
            rd_ptr_d = ZERO_C;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_RUN: begin
          if (iTIME_ZERO) begin
            rd_ptr_d = ZERO_C;
            ch_out_d = init_d;
          end else if (iTIME == cmp_time_q) begin
            ch_out_d = ~ch_out_q;
            rd_ptr_d = rd_ptr_q + ONE_C;
            if (rd_ptr_q == (count_q - ONE_C)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            ch_out_d = ch_out_q;
          end
        end
        ST_DONE: begin
          // An empty buffer has nothing to replay, so it simply stays done.
          if (iTIME_ZERO && (count_q != ZERO_C)) begin
            state_d  = ST_RUN;
            rd_ptr_d = ZERO_C;
            ch_out_d = init_d;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_FORCED: begin
          ch_out_d = ch_out_q;
        end
        default: begin
          state_d  = ST_IDLE;
          ch_out_d = init_d;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      ch_out_q  <= 1'b0;
      init_q    <= 1'b0;
      count_q   <= ZERO_C;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= ZERO_C;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_out_q  <= ch_out_d;
      init_q    <= init_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rd_ptr_q  <= rd_ptr_d;
      armed_q   <= (state_d == ST_ARMED);
      running_q <= (state_d == ST_RUN);
    end
  end

  // Time buffer: reading at the next pointer keeps cmp_time_q == mem[rd_ptr_q].
  always_ff @(posedge iCLK) begin
    if (wr_en_s) begin
      mem_q[count_q[AW-1:0]] <= iDATA_TIME;
    end
    cmp_time_q <= mem_q[rd_ptr_d[AW-1:0]];
  end

  assign oCH_OUT   = ch_out_q;
  assign oARMED    = armed_q;
  assign oRUNNING  = running_q;
  assign oCOUNT    = count_q;
  assign oOVERFLOW = ovf_q;

endmodule

// File: tb/tb_waveform_channel.sv
// Self-checking bench for waveform_channel (CH_ID=3, DEPTH=4): directed scenarios
// plus randomized waveforms checked against a toggle-count reference model.
module tb_waveform_channel;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iMODE_SET_CH_WAVEFORM = 1'b0;
  logic        iMODE_SET_CH_INIT_VAL = 1'b0;
  logic        iMODE_SET_CH_VAL_FORCED = 1'b0;
  logic        iMODE_CMD_ARM = 1'b0;
  logic        iMODE_CMD_TO_INIT = 1'b0;
  logic        iFLAG_TIME_READY = 1'b0;
  logic        iFLAG_CH_VAL_READY = 1'b0;
  logic [7:0]  iDATA_CHANNEL = 8'd0;
  logic [31:0] iDATA_TIME = 32'd0;
  logic        iDATA_CH_VAL = 1'b0;
  logic [31:0] iTIME = 32'd0;
  logic        iTIME_ZERO = 1'b0;
  logic        oCH_OUT, oARMED, oRUNNING, oOVERFLOW;
  logic [2:0]  oCOUNT;

  waveform_channel #(.CH_ID(8'd3), .DEPTH(4), .TW(32), .AW(2)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iMODE_SET_CH_WAVEFORM(iMODE_SET_CH_WAVEFORM),
    .iMODE_SET_CH_INIT_VAL(iMODE_SET_CH_INIT_VAL),
    .iMODE_SET_CH_VAL_FORCED(iMODE_SET_CH_VAL_FORCED),
    .iMODE_CMD_ARM(iMODE_CMD_ARM), .iMODE_CMD_TO_INIT(iMODE_CMD_TO_INIT),
    .iFLAG_TIME_READY(iFLAG_TIME_READY), .iFLAG_CH_VAL_READY(iFLAG_CH_VAL_READY),
    .iDATA_CHANNEL(iDATA_CHANNEL), .iDATA_TIME(iDATA_TIME), .iDATA_CH_VAL(iDATA_CH_VAL),
    .iTIME(iTIME), .iTIME_ZERO(iTIME_ZERO),
    .oCH_OUT(oCH_OUT), .oARMED(oARMED), .oRUNNING(oRUNNING),
    .oCOUNT(oCOUNT), .oOVERFLOW(oOVERFLOW)
  );

  always #10 iCLK = ~iCLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          tb_t = 0;
  int          tb_period = 1000;
  bit          tb_run = 1'b0;
  int          ld_n = 0;
  logic [7:0]  ld_ch = 8'd3;
  logic [31:0] ld_t [8];
  logic [31:0] exp_times [$];
  logic        exp_init = 1'b0;
  logic        exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, expv, tb_t);
    end
  endtask

  // One clock; the timebase advances and wraps when running.
  task automatic tick();
    @(posedge iCLK); #1;
    if (tb_run) begin
      tb_t = (tb_t == tb_period - 1) ? 0 : tb_t + 1;
      iTIME = 32'(tb_t);
      iTIME_ZERO = (tb_t == 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int n_before(input int t);
    int n = 0;
    foreach (exp_times[i]) if (exp_times[i] < 32'(t)) n++;
    return n;
  endfunction

  function automatic logic exp_out(input int t, input bit first);
    int n;
    if (t == 0 && first) return exp_init;
    n = n_before((t == 0) ? tb_period : t);
    return exp_init ^ n[0];
  endfunction

  function automatic logic exp_running(input int t);
    return (exp_times.size() > 0) && (n_before(t) < exp_times.size());
  endfunction

  task automatic load_wave();
    iMODE_SET_CH_WAVEFORM = 1'b1; ticks(5);
    exp_times.delete(); exp_ovf = 1'b0;
    for (int i = 0; i < ld_n; i++) begin
      iDATA_CHANNEL = ld_ch; iDATA_TIME = ld_t[i];
      iFLAG_TIME_READY = 1'b1; ticks(4);
      iFLAG_TIME_READY = 1'b0; ticks(4);
      if (ld_ch == 8'd3 && ld_t[i] != 32'd0) begin
        if (exp_times.size() < 4) exp_times.push_back(ld_t[i]);
        else exp_ovf = 1'b1;
      end
    end
    iMODE_SET_CH_WAVEFORM = 1'b0; ticks(4);
  endtask

  task automatic set_val(input bit forced, input logic [7:0] ch, input logic v);
    if (forced) iMODE_SET_CH_VAL_FORCED = 1'b1; else iMODE_SET_CH_INIT_VAL = 1'b1;
    ticks(4);
    iDATA_CHANNEL = ch; iDATA_CH_VAL = v;
    iFLAG_CH_VAL_READY = 1'b1; ticks(4);
    iFLAG_CH_VAL_READY = 1'b0; ticks(4);
    iMODE_SET_CH_VAL_FORCED = 1'b0; iMODE_SET_CH_INIT_VAL = 1'b0; ticks(2);
    if (!forced && ch == 8'd3) exp_init = v;
  endtask

  task automatic arm();
    iMODE_CMD_ARM = 1'b1; ticks(4); iMODE_CMD_ARM = 1'b0; ticks(4);
  endtask

  task automatic to_init();
    iMODE_CMD_TO_INIT = 1'b1; ticks(4); iMODE_CMD_TO_INIT = 1'b0; ticks(4);
  endtask

  task automatic start_run(input int period);
    tb_period = period; tb_t = 0; iTIME = 32'd0; iTIME_ZERO = 1'b1; tb_run = 1'b1;
  endtask

  task automatic stop_run();
    tb_run = 1'b0; iTIME_ZERO = 1'b0;
  endtask

  task automatic run_check(input int n, input bit first_in);
    bit first = first_in;
    for (int i = 0; i < n; i++) begin
      chk("ch_out", 32'(oCH_OUT), 32'(exp_out(tb_t, first)));
      if (tb_t != 0) chk("running", 32'(oRUNNING), 32'(exp_running(tb_t)));
      first = 1'b0;
      tick();
    end
  endtask

  task automatic set_times3(input int a, input int b, input int c, input int n);
    ld_ch = 8'd3; ld_n = n;
    ld_t[0] = 32'(a); ld_t[1] = 32'(b); ld_t[2] = 32'(c);
  endtask

  initial begin
    int t;
    ticks(3);
    chk("rst_out", 32'(oCH_OUT), 32'd0);
    chk("rst_count", 32'(oCOUNT), 32'd0);
    chk("rst_ovf", 32'(oOVERFLOW), 32'd0);
    chk("rst_armed", 32'(oARMED), 32'd0);
    chk("rst_running", 32'(oRUNNING), 32'd0);
    iRST = 1'b0; ticks(2);

    // Basic playback 10/20/35.
    set_val(1'b0, 8'd3, 1'b0);
    set_times3(10, 20, 35, 3); load_wave();
    chk("basic_count", 32'(oCOUNT), 32'd3);
    arm();
    chk("basic_armed", 32'(oARMED), 32'd1);
    start_run(1000); run_check(45, 1'b1);
    chk("basic_done_running", 32'(oRUNNING), 32'd0);
    chk("basic_done_out", 32'(oCH_OUT), 32'd1);
    stop_run(); to_init();
    chk("basic_toinit_out", 32'(oCH_OUT), 32'(exp_init));

    // Times for another channel are ignored; empty buffer goes straight to done.
    set_val(1'b0, 8'd3, 1'b1);
    chk("init_follow", 32'(oCH_OUT), 32'd1);
    ld_ch = 8'd5; ld_n = 4;
    for (int i = 0; i < 4; i++) ld_t[i] = 32'(10 * (i + 1));
    load_wave();
    chk("other_ch_count", 32'(oCOUNT), 32'd0);
    arm(); start_run(1000); run_check(20, 1'b1);
    chk("other_ch_armed", 32'(oARMED), 32'd0);
    stop_run(); to_init();

    // Overflow with five writes, cleared by a new waveform entry.
    set_val(1'b0, 8'd3, 1'b0);
    ld_ch = 8'd3; ld_n = 5;
    for (int i = 0; i < 5; i++) ld_t[i] = 32'(10 * (i + 1));
    load_wave();
    chk("ovf_count", 32'(oCOUNT), 32'd4);
    chk("ovf_flag", 32'(oOVERFLOW), 32'(exp_ovf));
    ld_n = 0; load_wave();
    chk("ovf_clr_count", 32'(oCOUNT), 32'd0);
    chk("ovf_clr_flag", 32'(oOVERFLOW), 32'd0);

    // Forced value overrides playback until TO_INIT.
    set_times3(10, 20, 35, 3); load_wave(); arm();
    start_run(1000); run_check(13, 1'b1);
    set_val(1'b1, 8'd3, 1'b1);
    for (int i = 0; i < 15; i++) begin
      chk("forced_out", 32'(oCH_OUT), 32'd1);
      chk("forced_running", 32'(oRUNNING), 32'd0);
      tick();
    end
    stop_run(); to_init();
    chk("forced_toinit_out", 32'(oCH_OUT), 32'd0);
    chk("forced_toinit_run", 32'(oRUNNING), 32'd0);

    // Period wrap at 30 with times 5 and 50.
    set_times3(5, 50, 0, 2); load_wave(); arm();
    start_run(30); run_check(70, 1'b1);
    stop_run(); to_init();

    // Randomized waveforms.
    for (int it = 0; it < 10; it++) begin
      set_val(1'b0, 8'd3, 1'($urandom_range(0, 1)));
      chk("rnd_init_out", 32'(oCH_OUT), 32'(exp_init));
      ld_ch = ($urandom_range(0, 5) == 0) ? 8'd5 : 8'd3;
      ld_n = $urandom_range(0, 6);
      t = 0;
      for (int i = 0; i < ld_n; i++) begin
        t += $urandom_range(1, 15);
        ld_t[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'(t);
      end
      load_wave();
      chk("rnd_count", 32'(oCOUNT), 32'(exp_times.size()));
      chk("rnd_ovf", 32'(oOVERFLOW), 32'(exp_ovf));
      arm();
      chk("rnd_armed", 32'(oARMED), 32'd1);
      t = $urandom_range(40, 90);
      start_run(t); run_check(2 * t + 10, 1'b1);
      stop_run(); to_init();
      chk("rnd_toinit_armed", 32'(oARMED), 32'd0);
    end

    // Reset in the middle of playback with the output high.
    set_val(1'b0, 8'd3, 1'b0);
    set_times3(10, 20, 35, 3); load_wave(); arm();
    start_run(1000); run_check(16, 1'b1);
    chk("rst_mid_pre_out", 32'(oCH_OUT), 32'd1);
    iRST = 1'b1; tick();
    chk("rst_mid_out", 32'(oCH_OUT), 32'd0);
    chk("rst_mid_count", 32'(oCOUNT), 32'd0);
    chk("rst_mid_armed", 32'(oARMED), 32'd0);
    chk("rst_mid_running", 32'(oRUNNING), 32'd0);
    iRST = 1'b0; stop_run(); ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
